// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone arbiter sharing one memory port between the
// icache (I) and dcache (D) controllers. Ties go to the port not served last.
// Optional build macro WB_ARBITER_TIMEOUT_EN adds an 8-bit grant watchdog that
// retries the owning master after 256 cycles without a memory response.
module wb_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    // I-port (icache)
    input  logic [11:0]  ic_adr,
    input  logic         ic_stb,
    input  logic         ic_cyc,
    input  logic         ic_we,
    input  logic [15:0]  ic_sel,
    input  logic [127:0] ic_dat_m,
    output logic [127:0] ic_dat_s,
    output logic         ic_ack,
    output logic         ic_rty,
    // D-port (dcache)
    input  logic [11:0]  dc_adr,
    input  logic         dc_stb,
    input  logic         dc_cyc,
    input  logic         dc_we,
    input  logic [15:0]  dc_sel,
    input  logic [127:0] dc_dat_m,
    output logic [127:0] dc_dat_s,
    output logic         dc_ack,
    output logic         dc_rty,
    // M-port (shared memory)
    output logic [11:0]  mem_adr,
    output logic         mem_stb,
    output logic         mem_cyc,
    output logic         mem_we,
    output logic [15:0]  mem_sel,
    output logic [127:0] mem_dat_m,
    input  logic [127:0] mem_dat_s,
    input  logic         mem_ack,
    input  logic         mem_rty,
    // status
    output logic         gnt_i,
    output logic         gnt_d
);

    localparam int unsigned ADR_W = 12;
    localparam int unsigned SEL_W = 16;
    localparam int unsigned DAT_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_t state;
    logic   last_gnt;
    logic   armed;      // low for the first edge after reset so no grant lands on it
    logic   req_i;
    logic   req_d;
    logic   own_req;
    logic   tmo;

    assign req_i   = ic_stb & ic_cyc;
    assign req_d   = dc_stb & dc_cyc;
    assign gnt_i   = (state == GNT_I);
    assign gnt_d   = (state == GNT_D);
    assign own_req = gnt_i ? req_i : req_d;

`ifdef WB_ARBITER_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign tmo = (state != IDLE) && (tmo_cnt == 8'hFF);

    // Watchdog: zero while idle (so it starts at 0 on grant entry), counts grant cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 8'h00;
        end else if (state == IDLE || mem_ack || mem_rty) begin
            tmo_cnt <= 8'h00;
        end else begin
            tmo_cnt <= tmo_cnt + 8'h01;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Grant FSM with round-robin tie break; every grant ends through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= LAST_I;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (armed) begin
                        if (req_i && req_d) begin
                            state <= (last_gnt == LAST_I) ? GNT_D : GNT_I;
                        end else if (req_i) begin
                            state <= GNT_I;
                        end else if (req_d) begin
                            state <= GNT_D;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_ack || mem_rty || !own_req || tmo) begin
                        state    <= IDLE;
                        last_gnt <= (state == GNT_I) ? LAST_I : LAST_D;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream request mux; everything forced to zero while idle
    always_comb begin
        mem_adr   = ADR_W'(0);
        mem_sel   = SEL_W'(0);
        mem_dat_m = DAT_W'(0);
        mem_we    = 1'b0;
        mem_stb   = 1'b0;
        mem_cyc   = 1'b0;
        case (state)
            GNT_I: begin
                mem_adr   = ic_adr;
                mem_sel   = ic_sel;
                mem_dat_m = ic_dat_m;
                mem_we    = ic_we;
                mem_stb   = ic_stb & ~tmo;
                mem_cyc   = ic_cyc & ~tmo;
            end
            GNT_D: begin
                mem_adr   = dc_adr;
                mem_sel   = dc_sel;
                mem_dat_m = dc_dat_m;
                mem_we    = dc_we;
                mem_stb   = dc_stb & ~tmo;
                mem_cyc   = dc_cyc & ~tmo;
            end
            default: ;
        endcase
    end

    // Read data fans out to both masters; only the response strobes are gated
    assign ic_dat_s = mem_dat_s;
    assign dc_dat_s = mem_dat_s;
    assign ic_ack   = mem_ack & gnt_i;
    assign dc_ack   = mem_ack & gnt_d;
    assign ic_rty   = (mem_rty | tmo) & gnt_i;
    assign dc_rty   = (mem_rty | tmo) & gnt_d;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single grants, tie break, alternation,
// abandon, retry forwarding, asynchronous reset and the long-wait window.
module tb_wb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [11:0]  ic_adr;
    logic         ic_stb;
    logic         ic_cyc;
    logic         ic_we;
    logic [15:0]  ic_sel;
    logic [127:0] ic_dat_m;
    logic [127:0] ic_dat_s;
    logic         ic_ack;
    logic         ic_rty;
    logic [11:0]  dc_adr;
    logic         dc_stb;
    logic         dc_cyc;
    logic         dc_we;
    logic [15:0]  dc_sel;
    logic [127:0] dc_dat_m;
    logic [127:0] dc_dat_s;
    logic         dc_ack;
    logic         dc_rty;
    logic [11:0]  mem_adr;
    logic         mem_stb;
    logic         mem_cyc;
    logic         mem_we;
    logic [15:0]  mem_sel;
    logic [127:0] mem_dat_m;
    logic [127:0] mem_dat_s;
    logic         mem_ack;
    logic         mem_rty;
    logic         gnt_i;
    logic         gnt_d;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] DAT_I  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] DAT_D  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    localparam logic [127:0] DAT_RD = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;

    wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ic_adr    (ic_adr),
        .ic_stb    (ic_stb),
        .ic_cyc    (ic_cyc),
        .ic_we     (ic_we),
        .ic_sel    (ic_sel),
        .ic_dat_m  (ic_dat_m),
        .ic_dat_s  (ic_dat_s),
        .ic_ack    (ic_ack),
        .ic_rty    (ic_rty),
        .dc_adr    (dc_adr),
        .dc_stb    (dc_stb),
        .dc_cyc    (dc_cyc),
        .dc_we     (dc_we),
        .dc_sel    (dc_sel),
        .dc_dat_m  (dc_dat_m),
        .dc_dat_s  (dc_dat_s),
        .dc_ack    (dc_ack),
        .dc_rty    (dc_rty),
        .mem_adr   (mem_adr),
        .mem_stb   (mem_stb),
        .mem_cyc   (mem_cyc),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_dat_m (mem_dat_m),
        .mem_dat_s (mem_dat_s),
        .mem_ack   (mem_ack),
        .mem_rty   (mem_rty),
        .gnt_i     (gnt_i),
        .gnt_d     (gnt_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int rty_at;
        int n;

        rst_n     = 1'b0;
        ic_adr    = 12'h000; ic_stb = 1'b0; ic_cyc = 1'b0; ic_we = 1'b0;
        ic_sel    = 16'h0000; ic_dat_m = 128'h0;
        dc_adr    = 12'h000; dc_stb = 1'b0; dc_cyc = 1'b0; dc_we = 1'b0;
        dc_sel    = 16'h0000; dc_dat_m = 128'h0;
        mem_dat_s = 128'h0; mem_ack = 1'b0; mem_rty = 1'b0;

        // reset state, with memory strobes high that must not leak through
        #2;
        mem_ack = 1'b1; mem_rty = 1'b1;
        #1;
        chk("rst_gnt_i", 128'(gnt_i), 128'd0);
        chk("rst_gnt_d", 128'(gnt_d), 128'd0);
        chk("rst_ack_rty", 128'({ic_ack, dc_ack, ic_rty, dc_rty}), 128'd0);
        chk("rst_mem_ctl", 128'({mem_stb, mem_cyc, mem_we}), 128'd0);
        chk("rst_mem_adr_sel", 128'({mem_adr, mem_sel}), 128'd0);
        chk("rst_mem_dat_m", mem_dat_m, 128'd0);
        mem_ack = 1'b0; mem_rty = 1'b0;
        tick();
        tick();

        // I-only read; no grant on the first edge after reset release
        rst_n = 1'b1;
        ic_adr = 12'h0A3; ic_we = 1'b0; ic_sel = 16'hFFFF; ic_dat_m = DAT_I;
        ic_stb = 1'b1; ic_cyc = 1'b1;
        tick();
        chk("first_edge_no_gnt", 128'(gnt_i), 128'd0);
        tick();
        chk("i_gnt", 128'(gnt_i), 128'd1);
        chk("i_mem_adr", 128'(mem_adr), 128'h0A3);
        chk("i_mem_we_stb_cyc", 128'({mem_we, mem_stb, mem_cyc}), 128'b011);
        tick();
        chk("i_no_early_ack", 128'(ic_ack), 128'd0);
        tick();
        mem_ack = 1'b1; mem_dat_s = DAT_RD;
        #1;
        chk("i_ack", 128'(ic_ack), 128'd1);
        chk("i_dc_ack_zero", 128'(dc_ack), 128'd0);
        chk("i_dat_s", ic_dat_s, DAT_RD);
        chk("d_dat_s_fanout", dc_dat_s, DAT_RD);
        tick();
        mem_ack = 1'b0; ic_stb = 1'b0; ic_cyc = 1'b0;
        #1;
        chk("i_done_idle", 128'({gnt_i, gnt_d, ic_ack, mem_stb}), 128'd0);

        // fresh reset, then a tie: D wins first
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        dc_adr = 12'h055; dc_we = 1'b1; dc_sel = 16'h00F0; dc_dat_m = DAT_D;
        dc_stb = 1'b1; dc_cyc = 1'b1; ic_stb = 1'b1; ic_cyc = 1'b1;
        tick();
        chk("tie_wait_arm", 128'({gnt_i, gnt_d}), 128'd0);
        tick();
        chk("tie_d_first", 128'({gnt_i, gnt_d}), 128'b01);
        chk("tie_d_we_sel", 128'({mem_we, mem_sel}), 128'h100F0);
        chk("tie_d_adr", 128'(mem_adr), 128'h055);
        chk("tie_d_dat_m", mem_dat_m, DAT_D);
        tick();
        mem_ack = 1'b1;
        #1;
        chk("tie_d_ack", 128'({ic_ack, dc_ack}), 128'b01);
        tick();
        mem_ack = 1'b0; dc_stb = 1'b0; dc_cyc = 1'b0;
        #1;
        chk("tie_idle_between", 128'({gnt_i, gnt_d, mem_we, mem_sel}), 128'd0);
        tick();
        chk("tie_i_second", 128'({gnt_i, gnt_d}), 128'b10);
        chk("tie_i_mux", 128'({mem_we, mem_adr, mem_sel}), 128'h0_0A3_FFFF);
        mem_ack = 1'b1;
        #1;
        chk("tie_i_ack", 128'({ic_ack, dc_ack}), 128'b10);
        tick();
        mem_ack = 1'b0; ic_stb = 1'b0; ic_cyc = 1'b0;

        // both continuously requesting, memory acks at once: D,I,D,I,D,I
        ic_stb = 1'b1; ic_cyc = 1'b1; dc_stb = 1'b1; dc_cyc = 1'b1; mem_ack = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("alt_gnt_d_%0d", k), 128'(gnt_d), 128'((k % 4) == 1));
            chk($sformatf("alt_gnt_i_%0d", k), 128'(gnt_i), 128'((k % 4) == 3));
        end
        ic_stb = 1'b0; ic_cyc = 1'b0; dc_stb = 1'b0; dc_cyc = 1'b0; mem_ack = 1'b0;

        // D abandons two cycles in; pending I served after one IDLE cycle
        dc_stb = 1'b1; dc_cyc = 1'b1;
        tick();
        chk("ab_d_gnt", 128'(gnt_d), 128'd1);
        ic_stb = 1'b1; ic_cyc = 1'b1;
        tick();
        chk("ab_i_waits", 128'({gnt_i, gnt_d}), 128'b01);
        dc_stb = 1'b0;
        #1;
        chk("ab_no_stb", 128'({mem_stb, gnt_d}), 128'b01);
        tick();
        dc_cyc = 1'b0;
        chk("ab_idle", 128'({gnt_i, gnt_d}), 128'd0);
        tick();
        chk("ab_i_gnt", 128'({gnt_i, gnt_d}), 128'b10);
        chk("ab_i_adr", 128'(mem_adr), 128'h0A3);

        // retry forwarded only to the owner, then re-grant
        mem_rty = 1'b1;
        #1;
        chk("rty_i", 128'({ic_rty, dc_rty, ic_ack}), 128'b100);
        tick();
        mem_rty = 1'b0;
        chk("rty_idle", 128'(gnt_i), 128'd0);
        tick();
        chk("rty_regnt", 128'(gnt_i), 128'd1);

        // asynchronous reset while memory acks
        mem_ack = 1'b1;
        #1;
        chk("ar_ack_before", 128'(ic_ack), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_ack_drop", 128'({ic_ack, dc_ack, ic_rty, dc_rty}), 128'd0);
        chk("ar_gnt_drop", 128'({gnt_i, gnt_d}), 128'd0);
        chk("ar_mem_zero", 128'({mem_stb, mem_cyc, mem_we, mem_adr, mem_sel}), 128'd0);
        tick();
        chk("ar_held", 128'({gnt_i, ic_ack}), 128'd0);
        mem_ack = 1'b0; ic_stb = 1'b0; ic_cyc = 1'b0;
        rst_n = 1'b1;

        // memory never answers a D request
        dc_stb = 1'b1; dc_cyc = 1'b1;
        tick();
        tick();
        chk("wait_d_gnt", 128'({gnt_d, dc_rty}), 128'b10);
`ifdef WB_ARBITER_TIMEOUT_EN
        rty_at = 0;
        n = 1;
        for (int i = 0; i < 1000 && rty_at == 0; i++) begin
            tick();
            n++;
            if (dc_rty === 1'b1) rty_at = n;
        end
        chk("tmo_rty_cycle", 128'(rty_at), 128'd256);
        tick();
        chk("tmo_idle", 128'(gnt_d), 128'd0);
`else
        bad = 0;
        rty_at = 0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            n++;
            if (gnt_d !== 1'b1 || dc_rty !== 1'b0) bad++;
        end
        chk("hold_1000", 128'(bad), 128'd0);
        chk("hold_cycles", 128'(n), 128'd1000);
        chk("hold_no_rty", 128'(rty_at), 128'd0);
`endif
        dc_stb = 1'b0; dc_cyc = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
